// File: rtl/adc_serial_reader_if.sv
// adc_serial_reader_if: result handshake toward the sample buffer.
// master drives data/valid, slave answers with ready.
interface adc_serial_reader_if #(
  parameter int DATA_BITS = 12
);
  logic [DATA_BITS-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: CONVST, conversion wait, then one serial frame per sample.
// Optional ADC_AVG_EN: emit the mean of every four frames.
module adc_serial_reader #(
  parameter int CYCLE_COUNT_MAX = 4,
  parameter int HALF_CYCLES     = 2,
  parameter int CNT_W           = 2,
  parameter int DATA_BITS       = 12,
  parameter int CFG_BITS        = 6,
  parameter int CONV_WAIT       = 20
) (
  input  logic                CLOCK_50,
  input  logic                resetN,
  input  logic                clkCounterEn,
  input  logic [CNT_W-1:0]    sclkCounter,
  input  logic                start,
  input  logic                continuous,
  input  logic [CFG_BITS-1:0] cfg_word,
  input  logic                adc_dout,
  output logic                adc_convst,
  output logic                adc_sclk,
  output logic                adc_din,
  adc_serial_reader_if.master smp,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } state_t;

  localparam int CW_W = $clog2(CONV_WAIT + 1);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] PH_HI =
    CNT_W'(HALF_CYCLES);
  localparam logic [CNT_W:0] PH_END =
    (CNT_W+1)'(CYCLE_COUNT_MAX);
  localparam logic [CW_W-1:0] CW_LAST =
    CW_W'(CONV_WAIT - 1);
  localparam logic [CW_W-1:0] CW_ONE = CW_W'(1);
  localparam logic [BC_W-1:0] BC_LAST =
    BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

  state_t state;
  state_t state_nxt;

  logic rise_ev;
  logic fall_ev;
  logic sclk_ph;

  logic arm;
  logic conv_end;
  logic conv_tick;
  logic go_shift;
  logic bit_tick;
  logic din_tick;
  logic done;

  logic                 pend;
  logic [CW_W-1:0]      conv_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [CFG_BITS-1:0]  cfg_sr;
  logic [DATA_BITS-1:0] res_sr;

  logic                 load;
  logic [DATA_BITS-1:0] load_val;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  assign rise_ev = clkCounterEn && (sclkCounter == PH_HI);
  assign fall_ev = clkCounterEn && (sclkCounter == '0);

  // high half of the SCLK period, bounded by the generator wrap
  assign sclk_ph = (sclkCounter >= PH_HI) &&
                   ({1'b0, sclkCounter} < PH_END);

  // state register and its registered busy image
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // next state and per-event datapath strobes
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    conv_end  = 1'b0;
    conv_tick = 1'b0;
    go_shift  = 1'b0;
    bit_tick  = 1'b0;
    din_tick  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall_ev && start) begin
          arm       = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (fall_ev) begin
          unique case (1'b1)
            pend: arm = 1'b1;
            (!pend && adc_convst): conv_end = 1'b1;
            (!pend && !adc_convst &&
             conv_cnt == CW_LAST): begin
              go_shift  = 1'b1;
              state_nxt = SHIFT;
            end
            default: conv_tick = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        if (rise_ev) begin
          bit_tick = 1'b1;
          if (bit_cnt == BC_LAST) begin
            state_nxt = DONE;
          end
        end
        if (fall_ev) begin
          din_tick = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = continuous ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // convst pulse, wait count, config shift-out and result shift-in
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      adc_convst <= 1'b0;
      adc_din    <= 1'b0;
      adc_sclk   <= 1'b0;
      pend       <= 1'b0;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      cfg_sr     <= '0;
      res_sr     <= '0;
    end else begin
      if (arm) begin
        cfg_sr     <= cfg_word;
        adc_convst <= 1'b1;
        pend       <= 1'b0;
      end
      if (conv_end) begin
        adc_convst <= 1'b0;
      end
      if (conv_tick) begin
        conv_cnt <= conv_cnt + CW_ONE;
      end
      if (go_shift || din_tick) begin
        adc_din <= cfg_sr[CFG_BITS-1];
        cfg_sr  <= cfg_sr << 1;
      end
      if (go_shift) begin
        conv_cnt <= '0;
        bit_cnt  <= '0;
      end
      if (bit_tick) begin
        res_sr  <= {res_sr[DATA_BITS-2:0], adc_dout};
        bit_cnt <= bit_cnt + BC_ONE;
      end
      if (done) begin
        adc_din <= 1'b0;
        pend    <= continuous;
      end
      adc_sclk <= (state == SHIFT) && sclk_ph;
    end
  end

`ifdef ADC_AVG_EN
  logic                 avg_clr;
  logic [1:0]           fcnt;
  logic [DATA_BITS+1:0] acc;
  logic [DATA_BITS+1:0] acc_sum;

  assign avg_clr  = (state == IDLE) && !start;
  assign acc_sum  = acc + {2'b00, res_sr};
  assign load     = done && (fcnt == 2'd3);
  assign load_val = acc_sum[DATA_BITS+1:2];

  // four-frame accumulator, restarted after each averaged load
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      fcnt <= '0;
      acc  <= '0;
    end else if (done) begin
      fcnt <= fcnt + 2'd1;
      acc  <= (fcnt == 2'd3) ? '0 : acc_sum;
    end else if (avg_clr) begin
      fcnt <= '0;
      acc  <= '0;
    end
  end
`else
  assign load     = done;
  assign load_val = res_sr;
`endif

  // result holding register, handshake and sticky overrun
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= load_val;
        valid_q <= 1'b1;
      end else if (smp.sample_ready) begin
        valid_q <= 1'b0;
      end
      if (load && valid_q && !smp.sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: random frames against a serial ADC model.
// Expected results come from the frame rules, not the RTL.
module tb_adc_serial_reader;

  localparam int CYC   = 4;
  localparam int HALF  = 2;
  localparam int CW    = 2;
  localparam int DB    = 12;
  localparam int CB    = 6;
  localparam int CWAIT = 20;
  localparam int LAT   = (1 + CWAIT + DB) * CYC;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [CB-1:0] cfg_word = '0;
  logic          adc_dout = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          adc_convst;
  logic          adc_sclk;
  logic          adc_din;
  logic          overrun;
  logic          busy;

  adc_serial_reader_if #(.DATA_BITS(DB)) smp ();

  adc_serial_reader #(
    .CYCLE_COUNT_MAX(CYC),
    .HALF_CYCLES(HALF),
    .CNT_W(CW),
    .DATA_BITS(DB),
    .CFG_BITS(CB),
    .CONV_WAIT(CWAIT)
  ) dut (
    .CLOCK_50(clk),
    .resetN(resetN),
    .clkCounterEn(en),
    .sclkCounter(cnt),
    .start(start),
    .continuous(continuous),
    .cfg_word(cfg_word),
    .adc_dout(adc_dout),
    .adc_convst(adc_convst),
    .adc_sclk(adc_sclk),
    .adc_din(adc_din),
    .smp(smp),
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // free-running phase counter of the SCLK generator
  always @(posedge clk)
    if (en) cnt <= (cnt == CW'(CYC - 1)) ? '0 : cnt + 1'b1;

  // ADC model: value chosen at CONVST rise, MSB first
  logic [DB-1:0] adc_q[$];
  logic [DB-1:0] adc_cur = '0;
  int            adc_idx = 0;
  int            conv_rises = 0;

  always @(posedge adc_convst) begin
    conv_rises++;
    if (adc_q.size() > 0) adc_cur = adc_q.pop_front();
    else adc_cur = DB'($urandom);
  end

  always @(negedge adc_convst) begin
    adc_idx  = DB - 1;
    adc_dout = adc_cur[DB-1];
  end

  always @(negedge adc_sclk)
    if (adc_idx > 0) begin
      adc_idx--;
      adc_dout = adc_cur[adc_idx];
    end

  // bus monitors
  int            pulses = 0;
  int            conv_hi = 0;
  bit            valid_seen = 0;
  logic [DB-1:0] din_log = '0;
  logic [DB-1:0] acc_q[$];

  always @(posedge adc_sclk) begin
    pulses++;
    din_log = {din_log[DB-2:0], adc_din};
  end

  always @(negedge clk) begin
    if (adc_convst === 1'b1) conv_hi++;
    if (smp.sample_valid === 1'b1) valid_seen = 1;
    if (smp.sample_valid === 1'b1 && smp.sample_ready === 1'b1)
      acc_q.push_back(smp.sample_data);
  end

  // config bits go out MSB first, then zeros
  function automatic logic [DB-1:0] din_model(
    input logic [CB-1:0] cfg
  );
    logic [DB-1:0] r;
    r = '0;
    for (int i = 0; i < DB; i++)
      if (i < CB) r[DB-1-i] = cfg[CB-1-i];
    return r;
  endfunction

  // start one frame and wait for the sample to appear
  task automatic run_frame(
    input  logic [CB-1:0] cfg,
    input  logic [DB-1:0] val,
    input  bit            freeze,
    output int            lat,
    output bit            to
  );
    bit seen;
    seen = 0;
    adc_q.push_back(val);
    pulses = 0;
    din_log = '0;
    conv_hi = 0;
    cfg_word = cfg;
    start = 1;
    lat = 0;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (adc_convst) begin
        seen = 1;
        start = 0;
      end
      if (seen) lat++;
      if (freeze && lat == 40) begin
        en = 0;
        repeat (50) begin
          @(negedge clk);
          lat++;
        end
        en = 1;
      end
      if (smp.sample_valid) begin
        to = 0;
        break;
      end
    end
    start = 0;
  endtask

  task automatic test_reset();
    resetN = 0;
    en = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({adc_convst, adc_sclk, adc_din} !== 3'b000) begin
      fails++;
      $display("FAIL reset_adc got %b want 000",
               {adc_convst, adc_sclk, adc_din});
    end
    tests++;
    if (smp.sample_valid !== 1'b0 || smp.sample_data !== '0) begin
      fails++;
      $display("FAIL reset_sample got v=%b d=%h want 0/0",
               smp.sample_valid, smp.sample_data);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_overrun got %b want 0", overrun);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    resetN = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    bit to;
    logic [CB-1:0] cfg;
    logic [DB-1:0] exp_din;
    cfg = 6'b100010;
    exp_din = din_model(cfg);
    smp.sample_ready = 0;
    run_frame(cfg, 12'hA5C, 0, lat, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL single_timeout no sample_valid");
    end
    tests++;
    if (smp.sample_data !== 12'hA5C) begin
      fails++;
      $display("FAIL single_data got %h want a5c",
               smp.sample_data);
    end
    tests++;
    if (conv_hi !== CYC) begin
      fails++;
      $display("FAIL single_convst got %0d want %0d",
               conv_hi, CYC);
    end
    tests++;
    if (din_log !== exp_din) begin
      fails++;
      $display("FAIL single_din got %b want %b",
               din_log, exp_din);
    end
    tests++;
    if (pulses !== DB) begin
      fails++;
      $display("FAIL single_sclk got %0d want %0d", pulses, DB);
    end
    tests++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      fails++;
      $display("FAIL single_latency got %0d want %0d+-1",
               lat, LAT);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL single_overrun got %b want 0", overrun);
    end
    smp.sample_ready = 1;
    @(negedge clk);
    smp.sample_ready = 0;
    tests++;
    if (smp.sample_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_accept got v=%b busy=%b want 0/0",
               smp.sample_valid, busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    bit to;
    logic [CB-1:0] cfg;
    logic [DB-1:0] val;
    logic [DB-1:0] exp_din;
    for (int k = 0; k < 3; k++) begin
      cfg = CB'($urandom);
      val = DB'($urandom);
      exp_din = din_model(cfg);
      run_frame(cfg, val, 0, lat, to);
      tests++;
      if (to || smp.sample_data !== val) begin
        fails++;
        $display("FAIL rand%0d_data got %h want %h to=%0d",
                 k, smp.sample_data, val, to);
      end
      tests++;
      if (din_log !== exp_din || pulses !== DB) begin
        fails++;
        $display("FAIL rand%0d_din got %b/%0d want %b/%0d",
                 k, din_log, pulses, exp_din, DB);
      end
      smp.sample_ready = 1;
      @(negedge clk);
      smp.sample_ready = 0;
      repeat (2 + $urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    int lat;
    bit to;
    logic [DB-1:0] val;
    val = DB'($urandom);
    run_frame(CB'($urandom), val, 1, lat, to);
    tests++;
    if (to || lat < LAT + 49 || lat > LAT + 51) begin
      fails++;
      $display("FAIL freeze_latency got %0d want %0d+-1",
               lat, LAT + 50);
    end
    tests++;
    if (smp.sample_data !== val) begin
      fails++;
      $display("FAIL freeze_data got %h want %h",
               smp.sample_data, val);
    end
    smp.sample_ready = 1;
    @(negedge clk);
    smp.sample_ready = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_continuous();
    logic [DB-1:0] exp_v[3];
    bit to;
    exp_v[0] = 12'h001;
    exp_v[1] = 12'hFFF;
    exp_v[2] = 12'h800;
    adc_q.delete();
    acc_q.delete();
    for (int k = 0; k < 3; k++) adc_q.push_back(exp_v[k]);
    conv_rises = 0;
    smp.sample_ready = 1;
    continuous = 1;
    start = 1;
    to = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (adc_convst) start = 0;
      if (conv_rises >= 3) continuous = 0;
      if (conv_rises >= 3 && !busy) begin
        to = 0;
        break;
      end
    end
    start = 0;
    continuous = 0;
    @(negedge clk);
    smp.sample_ready = 0;
    tests++;
    if (to || acc_q.size() != 3) begin
      fails++;
      $display("FAIL cont_count got %0d want 3 to=%0d",
               acc_q.size(), to);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= acc_q.size() || acc_q[k] !== exp_v[k]) begin
        fails++;
        $display("FAIL cont_value%0d want %h", k, exp_v[k]);
      end
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL cont_overrun got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    logic [DB-1:0] v1;
    logic [DB-1:0] v2;
    bit to;
    v1 = DB'($urandom);
    v2 = v1 ^ DB'($urandom_range(1, 4095));
    adc_q.delete();
    adc_q.push_back(v1);
    adc_q.push_back(v2);
    conv_rises = 0;
    smp.sample_ready = 0;
    continuous = 1;
    start = 1;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (adc_convst) start = 0;
      if (smp.sample_valid) continuous = 0;
      if (conv_rises >= 2 && !busy) begin
        to = 0;
        break;
      end
    end
    start = 0;
    continuous = 0;
    tests++;
    if (to || smp.sample_data !== v2) begin
      fails++;
      $display("FAIL ovr_data got %h want %h to=%0d",
               smp.sample_data, v2, to);
    end
    tests++;
    if (smp.sample_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_flag got v=%b o=%b want 1/1",
               smp.sample_valid, overrun);
    end
    overrun_clr = 1;
    @(negedge clk);
    overrun_clr = 0;
    tests++;
    if (overrun !== 1'b0 || smp.sample_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_clear got o=%b v=%b want 0/1",
               overrun, smp.sample_valid);
    end
    smp.sample_ready = 1;
    @(negedge clk);
    smp.sample_ready = 0;
    tests++;
    if (smp.sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_accept got %b want 0",
               smp.sample_valid);
    end
  endtask

  task automatic test_reset_shift();
    bit to;
    adc_q.delete();
    adc_q.push_back(DB'($urandom_range(1, 4095)));
    pulses = 0;
    cfg_word = CB'($urandom);
    start = 1;
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (adc_convst) start = 0;
      if (pulses >= 5) begin
        to = 0;
        break;
      end
    end
    start = 0;
    tests++;
    if (to) begin
      fails++;
      $display("FAIL rst_shift_timeout got %0d pulses", pulses);
    end
    @(posedge clk);
    #1 resetN = 0;
    #1;
    tests++;
    if ({adc_convst, adc_sclk, adc_din, smp.sample_valid,
         overrun, busy} !== 6'b0 || smp.sample_data !== '0) begin
      fails++;
      $display("FAIL rst_shift_out got %b d=%h want 0",
               {adc_convst, adc_sclk, adc_din,
                smp.sample_valid, overrun, busy},
               smp.sample_data);
    end
    @(negedge clk);
    resetN = 1;
    valid_seen = 0;
    repeat (200) @(negedge clk);
    tests++;
    if (valid_seen !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_shift_after got v=%b busy=%b want 0/0",
               valid_seen, busy);
    end
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg();
    logic [DB-1:0] v[4];
    logic [DB+1:0] sum;
    bit to;
    v[0] = 12'd100;
    v[1] = 12'd101;
    v[2] = 12'd102;
    v[3] = 12'd104;
    sum = '0;
    adc_q.delete();
    acc_q.delete();
    for (int k = 0; k < 4; k++) begin
      adc_q.push_back(v[k]);
      sum = sum + (DB+2)'(v[k]);
    end
    conv_rises = 0;
    smp.sample_ready = 1;
    continuous = 1;
    start = 1;
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (adc_convst) start = 0;
      if (conv_rises >= 4) continuous = 0;
      if (conv_rises >= 4 && !busy) begin
        to = 0;
        break;
      end
    end
    start = 0;
    continuous = 0;
    @(negedge clk);
    smp.sample_ready = 0;
    tests++;
    if (to || acc_q.size() != 1) begin
      fails++;
      $display("FAIL avg_count got %0d want 1 to=%0d",
               acc_q.size(), to);
    end
    tests++;
    if (acc_q.size() < 1 || acc_q[0] !== DB'(sum >> 2)) begin
      fails++;
      $display("FAIL avg_value want %0d", sum >> 2);
    end
  endtask
`endif

  initial begin
    smp.sample_ready = 0;
    test_reset();
`ifdef ADC_AVG_EN
    test_avg();
`else
    test_single();
    test_random();
    test_freeze();
    test_continuous();
    test_overrun();
`endif
    test_reset_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Downstream consumer of the SCLK counter stage.
- Uses the free-running sclkCounter phase to run one ADC transaction per start or continuously: CONVST pulse, conversion wait, then a serial frame. The frame shifts a channel config word out on adc_din and a DATA_BITS result in from adc_dout.
- Delivers each result on a valid/ready interface to the sample buffer.

Parameters:
- CYCLE_COUNT_MAX, 4, CLOCK_50 cycles per SCLK period; must equal the clock generator setting.
- HALF_CYCLES, 2, counter value at which SCLK goes high (ceil(CYCLE_COUNT_MAX/2)).
- CNT_W, 2, width of sclkCounter (clog2(CYCLE_COUNT_MAX), minimum 1).
- DATA_BITS, 12, result width.
- CFG_BITS, 6, config word width; must be <= DATA_BITS.
- CONV_WAIT, 20, SCLK periods between CONVST fall and the first frame SCLK (20 x 80 ns = 1.6 us).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetN  in  1  asynchronous active-low reset.
- clkCounterEn  in  1  same enable that drives the clock generator; qualifies all phase events.
- sclkCounter  in  CNT_W  phase from the clock generator.
- start  in  1  level; sampled at fall events in IDLE.
- continuous  in  1  when 1, DONE returns to CONV instead of IDLE.
- cfg_word  in  CFG_BITS  channel/mode word, captured at CONV entry.
- adc_dout  in  1  serial data from ADC.
- adc_convst  out  1  conversion start.
- adc_sclk  out  1  gated serial clock to ADC.
- adc_din  out  1  serial config to ADC.
- sample_data  out  DATA_BITS  last result.
- sample_valid  out  1  result available.
- sample_ready  in  1  consumer accepts when valid and ready are both 1.
- overrun  out  1  sticky: result lost.
- overrun_clr  in  1  clears overrun.
- busy  out  1  state != IDLE.

Behaviour:
- Events:
  - rise_ev = clkCounterEn and sclkCounter == HALF_CYCLES.
  - fall_ev = clkCounterEn and sclkCounter == 0.
  - With clkCounterEn low the FSM and all counters hold.
- All outputs are registered. State changes on the CLOCK_50 edge ending the event cycle.
- Reset (async, any state): state=IDLE, adc_convst=0, adc_din=0, adc_sclk=0, sample_data=0, sample_valid=0, overrun=0, busy=0, all counters 0.
- States:
  - IDLE: at fall_ev with start=1, capture cfg_word into the shift register, set adc_convst=1, go to CONV.
  - CONV: adc_convst held 1 for exactly one SCLK period (cleared at the next fall_ev). Then count CONV_WAIT fall_evs. At the CONV_WAIT-th fall_ev go to SHIFT and present cfg MSB on adc_din.
  - SHIFT:
    - adc_sclk = 1 while sclkCounter >= HALF_CYCLES, else 0. Registered, so 1 CLOCK_50 lag is allowed.
    - At each rise_ev: shift adc_dout into the result register, MSB first, and increment the bit count.
    - At each fall_ev: shift adc_din to the next cfg bit. After CFG_BITS bits, adc_din=0.
    - After the DATA_BITS-th rise_ev go to DONE, with adc_sclk forced 0 from the next cycle.
  - DONE (one CLOCK_50 cycle): load sample_data and set sample_valid=1. Then go to CONV if continuous=1 (waiting for the next fall_ev to pulse adc_convst, cfg_word recaptured then), else IDLE.
- Handshake:
  - sample_valid stays 1 until a cycle with sample_ready=1.
  - If a DONE load occurs while valid=1 and ready=0: sample_data is overwritten, valid stays 1, overrun is set.
  - If DONE coincides with ready=1: the old sample is accepted, the new one loads, valid stays 1, no overrun.
- overrun_clr and a simultaneous overrun set: set wins.
- Dropping start mid-transaction has no effect; the frame completes. Dropping continuous takes effect at DONE.
- Per-frame latency with defaults, CONV entry to sample_valid: (1 + CONV_WAIT) SCLK periods + DATA_BITS rises ≈ 33 SCLK periods (132 CLOCK_50 cycles) ± 1 cycle.

Optional Feature:
- Macro ADC_AVG_EN.
- Defined:
  - Adds a 2-bit frame counter and a DATA_BITS+2 accumulator.
  - sample_valid is raised only every 4th DONE, with sample_data = accumulator >> 2 (truncated). The accumulator then resets.
  - Overrun evaluated only at those loads.
  - Reset and IDLE entry from start=0 clear the frame counter and accumulator.
- Undefined: every DONE produces a sample; no extra logic.

Test Plan:
- Reset during SHIFT at bit 5 → all outputs 0 in the same cycle as resetN low; busy=0; no sample_valid after release.
- start=1 pulse, cfg_word=6'b100010, ADC model returns 12'hA5C → adc_convst high for exactly 4 CLOCK_50 cycles. adc_din sequence 1,0,0,0,1,0,0×6. sample_data=12'hA5C, sample_valid=1, exactly 12 adc_sclk high pulses.
- clkCounterEn low for 50 cycles mid-CONV → state and wait count frozen; total latency grows by exactly 50 cycles.
- continuous=1, sample_ready tied 1, results 12'h001,12'hFFF,12'h800 → three valid pulses with those values; overrun=0.
- sample_ready=0 across two frames → second value in sample_data, overrun=1. overrun_clr=1 → overrun=0.
- ADC_AVG_EN, samples 100,101,102,104 → single valid, sample_data=101.
